vpu_cmd_queue: RTL and testbench
================================

# vpu_cmd_queue

Parametrised command queue between the CPU decode/execute stage and the VPU, generalising the single-entry VPU interface register. DEX pushes one VPU command (instruction word plus NUM_VREGS vector registers) per cycle. The queue drains commands to the VPU one at a time using a start/ready handshake. The CPU stalls only when the queue is full, not on every VPU command.

## Interface
- DATA_W, 16: width of one vector register (V0..V7, RO).
- NUM_VREGS, 9: vector registers per command (V0..V7 plus RO).
- INSTR_W, 16: VPU instruction word width.
- DEPTH, 4: queue entries; power of two, minimum 2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  DEX VPU_start; enqueue command this cycle.
- push_instr  in  INSTR_W  instruction word for the command.
- push_vregs  in  NUM_VREGS*DATA_W  packed vector registers; V0 in the LSBs, RO in the MSBs.
- flush  in  1  discard all queued (not yet issued) commands.
- VPU_rdy  in  1  VPU idle and able to accept a command.
- STALL  out  1  queue full; DEX must hold the current instruction.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a push arrived while full.
- start_VPU  out  1  one-cycle command-start pulse to the VPU.
- instr_VPU  out  INSTR_W  issued instruction word; held until the next issue.
- vregs_VPU  out  NUM_VREGS*DATA_W  issued vector registers; held until the next issue.

## Operation
- Storage: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- STALL = (count == DEPTH). Combinational from the registered count.
- Push while full: command dropped, count unchanged, overflow set until rst.
- Push and pop in the same cycle when not full: both take effect, count unchanged.
- Issue FSM:
  - IDLE: if count != 0 and VPU_rdy, pop the head into instr_VPU/vregs_VPU, start_VPU=1, go to ACK.
  - ACK: start_VPU=0. On VPU_rdy == 0, go to BUSY.
  - BUSY: on VPU_rdy == 1, go to IDLE.
- Exactly one start_VPU pulse per command. No issue occurs outside IDLE.
- flush: count=0 and rd_ptr=wr_ptr. An in-flight command is unaffected and the FSM state is kept. A push in the same cycle as flush is dropped and does not set overflow.
- Reset: count 0, pointers 0, state IDLE, start_VPU 0, instr_VPU 0, vregs_VPU 0, overflow 0. Reset mid-transfer abandons the in-flight command; the VPU is reset alongside.

## Timing
- Push sampled at edge E0; count increments after E0.
- Earliest issue: start_VPU high in the cycle after edge E1, i.e. 2 cycles after push (bypass case below).
- Issue-to-issue minimum: 3 cycles (IDLE -> ACK -> BUSY -> IDLE), assuming the VPU drops rdy within one cycle of the start pulse.
- level and STALL update on the edge following the push or pop.
- instr_VPU/vregs_VPU change only on the issue edge and are stable while start_VPU is high.

## Configuration
- VPU_QUEUE_BYPASS_EN defined: the bypass applies when, at edge E0, the FSM is in IDLE, count == 0, VPU_rdy == 1 and push == 1. The command loads the output registers directly and start_VPU is high after E0 (1-cycle latency). Count and pointers are unchanged.
- VPU_QUEUE_BYPASS_EN undefined: every command passes through the buffer, with 2-cycle minimum latency.

## Test plan
- Single command, VPU_rdy=1, push instr=16'hA5C3, V0=16'h0001 … RO=16'h0009: one start_VPU pulse 2 cycles later (1 cycle with bypass); outputs equal the pushed values; level returns to 0.
- VPU_rdy=0, push 5 commands with DEPTH=4: STALL=1 after the 4th; the 5th is dropped and overflow=1; level=4. Then cycle VPU_rdy: exactly 4 pulses, in FIFO order.
- Full queue; push and VPU pop in the same cycle: push dropped, overflow=1, level=3.
- Level 2; simultaneous push and pop: level stays 2; pointers wrap correctly across 10 back-to-back commands, with output order matching push order.
- flush with 3 queued and one in flight: in-flight command completes; no further start_VPU pulse; level=0; overflow unchanged.
- rst asserted in BUSY with level=2: next cycle state IDLE, level 0, start_VPU 0, outputs 0; no pulse after VPU_rdy rises.

Source files
------------

// File: rtl/vpu_cmd_queue_if.sv
// Handshake/bus bundle between DEX, the VPU command queue and the VPU.
// master = DEX/VPU side driving commands and VPU_rdy; slave = the queue.
interface vpu_cmd_queue_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_VREGS = 9,
  parameter int INSTR_W   = 16,
  parameter int DEPTH     = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                          push;
  logic [INSTR_W-1:0]            push_instr;
  logic [NUM_VREGS*DATA_W-1:0]   push_vregs;
  logic                          flush;
  logic                          VPU_rdy;
  logic                          STALL;
  logic [LVL_W-1:0]              level;
  logic                          overflow;
  logic                          start_VPU;
  logic [INSTR_W-1:0]            instr_VPU;
  logic [NUM_VREGS*DATA_W-1:0]   vregs_VPU;

  modport master (
    output push, push_instr, push_vregs, flush, VPU_rdy,
    input  STALL, level, overflow, start_VPU, instr_VPU, vregs_VPU
  );

  modport slave (
    input  push, push_instr, push_vregs, flush, VPU_rdy,
    output STALL, level, overflow, start_VPU, instr_VPU, vregs_VPU
  );
endinterface

// File: rtl/vpu_cmd_queue.sv
// Circular command queue between DEX and the VPU with a start/ready issue FSM.
// Optional VPU_QUEUE_BYPASS_EN: an empty idle queue forwards a push straight to the VPU.
module vpu_cmd_queue #(
  parameter int DATA_W    = 16,
  parameter int NUM_VREGS = 9,
  parameter int INSTR_W   = 16,
  parameter int DEPTH     = 4
) (
  input logic           clk,
  input logic           rst,
  vpu_cmd_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = INSTR_W + NUM_VREGS * DATA_W;

  typedef enum logic [1:0] {IDLE, ACK, BUSY} state_t;

  state_t             state, state_nx;
  logic [CMD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty;
  logic               pop, bypass, do_push, issue;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef VPU_QUEUE_BYPASS_EN
  assign bypass = bus.push && !bus.flush && (state == IDLE) && empty && bus.VPU_rdy;
`else
  assign bypass = 1'b0;
`endif

  // A flush cycle drops the push and blocks issue from the buffer.
  assign do_push = bus.push && !bus.flush && !full && !bypass;
  assign issue   = pop || bypass;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && !empty && bus.VPU_rdy) begin
          pop      = 1'b1;
          state_nx = ACK;
        end else if (bypass) begin
          state_nx = ACK;
        end
      end
      ACK:     if (!bus.VPU_rdy) state_nx = BUSY;
      BUSY:    if (bus.VPU_rdy)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {bus.push_instr, bus.push_vregs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.overflow  <= 1'b0;
      bus.start_VPU <= 1'b0;
      bus.instr_VPU <= '0;
      bus.vregs_VPU <= '0;
    end else begin
      bus.start_VPU <= issue;
      if (pop)
        {bus.instr_VPU, bus.vregs_VPU} <= mem[rd_ptr];
      else if (bypass)
        {bus.instr_VPU, bus.vregs_VPU} <= {bus.push_instr, bus.push_vregs};
      if (bus.push && full && !bus.flush)
        bus.overflow <= 1'b1;
      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(pop);
      end
    end
  end

  assign bus.STALL = full;
  assign bus.level = count;
endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Scoreboard bench for vpu_cmd_queue: stimulus queues expected issues, a negedge monitor checks each start_VPU.
module tb_vpu_cmd_queue;
  localparam int DATA_W    = 16;
  localparam int NUM_VREGS = 9;
  localparam int INSTR_W   = 16;
  localparam int DEPTH     = 4;
  localparam int VW        = NUM_VREGS * DATA_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [VW-1:0]      vregs;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  logic vpu_hold = 1'b1;
  int   busy_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  vpu_cmd_queue_if #(.DATA_W(DATA_W), .NUM_VREGS(NUM_VREGS), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  vpu_cmd_queue #(.DATA_W(DATA_W), .NUM_VREGS(NUM_VREGS), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // VPU model: drops rdy for two cycles after each start pulse; vpu_hold forces it low.
  initial begin
    bus.VPU_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1)              busy_cnt = 0;
      else if (bus.start_VPU === 1'b1) busy_cnt = 2;
      else if (busy_cnt > 0)         busy_cnt--;
      bus.VPU_rdy = !vpu_hold && (busy_cnt == 0);
    end
  end

  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (bus.start_VPU === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: pulse with instr_VPU=%h, required no pulse", bus.instr_VPU);
        end else begin
          e = exp_q.pop_front();
          if ({bus.instr_VPU, bus.vregs_VPU} !== e) begin
            errors++;
            $display("FAIL issue_cmd: got instr %h vregs %h, required instr %h vregs %h",
                     bus.instr_VPU, bus.vregs_VPU, e.instr, e.vregs);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [VW-1:0] mkv(input logic [15:0] base);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_VREGS; i++) v[i*DATA_W +: DATA_W] = base + 16'(i + 1);
    return v;
  endfunction

  task automatic expect_cmd(input logic [15:0] instr, input logic [15:0] base);
    exp_q.push_back({instr, mkv(base)});
  endtask

  task automatic drive_push(input logic [15:0] instr, input logic [15:0] base);
    bus.push       = 1'b1;
    bus.push_instr = instr;
    bus.push_vregs = mkv(base);
    tick();
    bus.push = 1'b0;
  endtask

  // Bounded wait for all expected issues to be seen and the queue empty.
  task automatic wait_issue(input string name, input int budget, input int settle);
    int n = 0;
    while ((exp_q.size() != 0 || bus.level != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.level != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d pending and level %0d, required 0 and 0",
               name, exp_q.size(), bus.level);
    end
    repeat (settle) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int sent;
    int n;
    rst            = 1'b1;
    bus.push       = 1'b0;
    bus.flush      = 1'b0;
    bus.push_instr = '0;
    bus.push_vregs = '0;
    repeat (3) tick();
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_stall", 32'(bus.STALL), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_start", 32'(bus.start_VPU), 0);
    chk("rst_instr", 32'(bus.instr_VPU), 0);
    rst      = 1'b0;
    vpu_hold = 1'b0;
    tick();
    tick();

    // Single command latency and content
    expect_cmd(16'hA5C3, 16'h0000);
    drive_push(16'hA5C3, 16'h0000);
`ifdef VPU_QUEUE_BYPASS_EN
    chk("t1_start_e0", 32'(bus.start_VPU), 1);
    chk("t1_level_e0", 32'(bus.level), 0);
    tick();
    chk("t1_start_e1", 32'(bus.start_VPU), 0);
`else
    chk("t1_start_e0", 32'(bus.start_VPU), 0);
    chk("t1_level_e0", 32'(bus.level), 1);
    tick();
    chk("t1_start_e1", 32'(bus.start_VPU), 1);
    chk("t1_level_e1", 32'(bus.level), 0);
`endif
    wait_issue("t1_drain", 50, 6);

    // Fill with VPU not ready, overflow on fifth push
    vpu_hold = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_cmd(16'(16'h1000 + i), 16'(i * 16));
      drive_push(16'(16'h1000 + i), 16'(i * 16));
      if (i == 3) chk("t2_stall_after4", 32'(bus.STALL), 1);
    end
    chk("t2_overflow", 32'(bus.overflow), 1);
    chk("t2_level", 32'(bus.level), 4);
    vpu_hold = 1'b0;
    wait_issue("t2_drain", 100, 4);
    chk("t2_overflow_sticky", 32'(bus.overflow), 1);

    // Full queue, push and pop in the same cycle
    vpu_hold = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_cmd(16'(16'h2000 + i), 16'(16'h0100 + i * 16));
      drive_push(16'(16'h2000 + i), 16'(16'h0100 + i * 16));
    end
    chk("t3_level_full", 32'(bus.level), 4);
    chk("t3_overflow_pre", 32'(bus.overflow), 0);
    vpu_hold = 1'b0;
    drive_push(16'hDEAD, 16'h0F00);
    chk("t3_level", 32'(bus.level), 3);
    chk("t3_overflow", 32'(bus.overflow), 1);
    wait_issue("t3_drain", 100, 4);

    // Level 2 with simultaneous push and pop, then 10 back-to-back commands
    vpu_hold = 1'b1;
    do_reset();
    expect_cmd(16'h3000, 16'h0200);
    drive_push(16'h3000, 16'h0200);
    expect_cmd(16'h3001, 16'h0210);
    drive_push(16'h3001, 16'h0210);
    chk("t4_level2", 32'(bus.level), 2);
    vpu_hold = 1'b0;
    expect_cmd(16'h3002, 16'h0220);
    drive_push(16'h3002, 16'h0220);
    chk("t4_level_pushpop", 32'(bus.level), 2);
    wait_issue("t4_drain", 100, 2);
    sent = 0;
    n    = 0;
    while (sent < 10 && n < 300) begin
      if (!bus.STALL) begin
        expect_cmd(16'(16'h4000 + sent), 16'(16'h0400 + sent * 16));
        bus.push       = 1'b1;
        bus.push_instr = 16'(16'h4000 + sent);
        bus.push_vregs = mkv(16'(16'h0400 + sent * 16));
        sent++;
      end else begin
        bus.push = 1'b0;
      end
      tick();
      n++;
    end
    bus.push = 1'b0;
    chk("t4_all_sent", 32'(sent), 10);
    wait_issue("t4_wrap_drain", 300, 4);

    // Flush with one in flight and three queued
    do_reset();
    expect_cmd(16'h5000, 16'h0500);
    drive_push(16'h5000, 16'h0500);
    wait_issue("t5_inflight", 20, 0);
    vpu_hold = 1'b1;
    drive_push(16'h5001, 16'h0510);
    drive_push(16'h5002, 16'h0520);
    drive_push(16'h5003, 16'h0530);
    chk("t5_level3", 32'(bus.level), 3);
    bus.flush = 1'b1;
    drive_push(16'hBEEF, 16'h0540);
    bus.flush = 1'b0;
    chk("t5_level_flushed", 32'(bus.level), 0);
    chk("t5_overflow", 32'(bus.overflow), 0);
    vpu_hold = 1'b0;
    repeat (12) tick();
    chk("t5_level_after", 32'(bus.level), 0);

    // Reset while BUSY with two queued
    expect_cmd(16'h6000, 16'h0600);
    drive_push(16'h6000, 16'h0600);
    wait_issue("t6_inflight", 20, 0);
    vpu_hold = 1'b1;
    drive_push(16'h6001, 16'h0610);
    drive_push(16'h6002, 16'h0620);
    chk("t6_level2", 32'(bus.level), 2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_level_rst", 32'(bus.level), 0);
    chk("t6_start_rst", 32'(bus.start_VPU), 0);
    chk("t6_instr_rst", 32'(bus.instr_VPU), 0);
    chk("t6_vregs_rst", 32'(bus.vregs_VPU != '0), 0);
    rst      = 1'b0;
    vpu_hold = 1'b0;
    repeat (12) tick();
    chk("t6_level_after", 32'(bus.level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
